mem_stage_axil: RTL and testbench

- Parametrised load/store pipeline stage for the RV32 core. It sits between execute and writeback, driving the data-memory AXI-Lite master.
- Unlike a single-transaction, stall-everything memory stage, it uses a valid/ready request interface and supports up to MAX_OUTSTANDING in-order reads or writes in flight.
- It performs byte-lane alignment, sign/zero extension and strobe generation, and raises error reporting.

---
 rtl/mem_stage_axil_pkg.sv | 75 +++++++
 rtl/mem_stage_tag_fifo.sv | 57 +++++
 rtl/mem_stage_axil.sv | 183 ++++++++++++++++++
 tb/tb_mem_stage_axil.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_axil_pkg.sv
// Shared memory-access definitions: load/store type codes, AXI response codes,
// and the lane-extract / strobe helpers reused by the core.
package mem_stage_axil_pkg;

  localparam int LS_SEL = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [LS_SEL-1:0] {
    LS_TYPE_NONE = 4'd0,
    LS_TYPE_LB   = 4'd1,
    LS_TYPE_LH   = 4'd2,
    LS_TYPE_LW   = 4'd3,
    LS_TYPE_LBU  = 4'd4,
    LS_TYPE_LHU  = 4'd5,
    LS_TYPE_SB   = 4'd6,
    LS_TYPE_SH   = 4'd7,
    LS_TYPE_SW   = 4'd8
  } ls_type_e;

  function automatic logic f_Is_Load(input logic [LS_SEL-1:0] t);
    return t inside {LS_TYPE_LB, LS_TYPE_LH, LS_TYPE_LW, LS_TYPE_LBU, LS_TYPE_LHU};
  endfunction

  function automatic logic f_Is_Store(input logic [LS_SEL-1:0] t);
    return t inside {LS_TYPE_SB, LS_TYPE_SH, LS_TYPE_SW};
  endfunction

  function automatic logic f_Is_Misaligned(input logic [LS_SEL-1:0] t, input logic [1:0] off);
    if (t inside {LS_TYPE_LW, LS_TYPE_SW}) return off != 2'b00;
    if (t inside {LS_TYPE_LH, LS_TYPE_LHU, LS_TYPE_SH}) return off[0];
    return 1'b0;
  endfunction

  // Clears the low offset bits an access of this size cannot use.
  function automatic logic [1:0] f_Align_Offset(input logic [LS_SEL-1:0] t, input logic [1:0] off);
    if (t inside {LS_TYPE_LW, LS_TYPE_SW}) return 2'b00;
    if (t inside {LS_TYPE_LH, LS_TYPE_LHU, LS_TYPE_SH}) return {off[1], 1'b0};
    return off;
  endfunction

  function automatic logic [31:0] f_Lane_Extract(input logic [LS_SEL-1:0] t, input logic [1:0] off,
                                                 input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (t)
      LS_TYPE_LB:  return {{24{b[7]}}, b};
      LS_TYPE_LBU: return {24'd0, b};
      LS_TYPE_LH:  return {{16{h[15]}}, h};
      LS_TYPE_LHU: return {16'd0, h};
      default:     return word;
    endcase
  endfunction

  function automatic logic [31:0] f_Store_Data(input logic [LS_SEL-1:0] t, input logic [31:0] d);
    case (t)
      LS_TYPE_SB: return {4{d[7:0]}};
      LS_TYPE_SH: return {2{d[15:0]}};
      default:    return d;
    endcase
  endfunction

  function automatic logic [3:0] f_Store_Strobe(input logic [LS_SEL-1:0] t, input logic [1:0] off);
    case (t)
      LS_TYPE_SB: return 4'b0001 << off;
      LS_TYPE_SH: return 4'b0011 << {off[1], 1'b0};
      LS_TYPE_SW: return 4'b1111;
      default:    return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_tag_fifo.sv
// Synchronous tag FIFO holding per-load metadata until its R response returns.
// A push is accepted while full when a pop happens in the same cycle.
module mem_stage_tag_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: storage has no reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage_axil.sv
// RV32 load/store stage driving an AXI-Lite master with in-order outstanding transactions.
// Define MEM_STAGE_MISALIGN_TRAP_EN to fault misaligned requests instead of aligning them.
module mem_stage_axil
  import mem_stage_axil_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int RD_WIDTH        = 5,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_N,
  input  logic                  i_Req_Valid,
  output logic                  o_Req_Ready,
  input  logic [LS_SEL-1:0]     i_Load_Store_Type,
  input  logic [ADDR_WIDTH-1:0] i_Addr,
  input  logic [XLEN-1:0]       i_Store_Data,
  input  logic [RD_WIDTH-1:0]   i_Rd,
  output logic                  o_Wb_Valid,
  output logic [RD_WIDTH-1:0]   o_Wb_Rd,
  output logic [XLEN-1:0]       o_Wb_Data,
  output logic                  o_Store_Commit,
  output logic                  o_Fault,
  output logic                  o_Idle,
  output logic [ADDR_WIDTH-1:0] s_axil_araddr,
  output logic                  s_axil_arvalid,
  input  logic                  s_axil_arready,
  input  logic [XLEN-1:0]       s_axil_rdata,
  input  logic [1:0]            s_axil_rresp,
  input  logic                  s_axil_rvalid,
  output logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  output logic                  s_axil_awvalid,
  input  logic                  s_axil_awready,
  output logic [XLEN-1:0]       s_axil_wdata,
  output logic [3:0]            s_axil_wstrb,
  output logic                  s_axil_wvalid,
  input  logic                  s_axil_wready,
  input  logic [1:0]            s_axil_bresp,
  input  logic                  s_axil_bvalid,
  output logic                  s_axil_bready
);

  localparam int TAG_W = RD_WIDTH + LS_SEL + 2;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0]      rd_pending, wr_pending;
  logic                  is_load, is_store, misalign;
  logic                  accept, issue_ld, issue_st, r_hs, b_hs;
  logic                  ld_room, st_room, kind_ok;
  logic [1:0]            offset;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [TAG_W-1:0]      tag_in, tag_out;
  logic                  tag_full, tag_empty;
  logic [RD_WIDTH-1:0]   tag_rd;
  logic [LS_SEL-1:0]     tag_type;
  logic [1:0]            tag_off;

  assign is_load   = f_Is_Load(i_Load_Store_Type);
  assign is_store  = f_Is_Store(i_Load_Store_Type);
  assign offset    = f_Align_Offset(i_Load_Store_Type, i_Addr[1:0]);
  assign word_addr = {i_Addr[ADDR_WIDTH-1:2], 2'b00};

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign misalign = f_Is_Misaligned(i_Load_Store_Type, i_Addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign s_axil_rready = (rd_pending != '0);
  assign s_axil_bready = (wr_pending != '0);
  assign r_hs          = s_axil_rvalid && s_axil_rready;
  assign b_hs          = s_axil_bvalid && s_axil_bready;

  // A response retiring this cycle frees its slot for a same-cycle accept.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ld_room = !tag_full || r_hs;
    st_room = (wr_pending < CNT_W'(MAX_OUTSTANDING)) || b_hs;
    kind_ok = 1'b1;
    if (is_load)       kind_ok = ld_room && (wr_pending == '0);
    else if (is_store) kind_ok = st_room && (rd_pending == '0);
    o_Req_Ready = !s_axil_arvalid && !s_axil_awvalid && !s_axil_wvalid && kind_ok;
  end

  assign accept   = i_Req_Valid && o_Req_Ready;
  assign issue_ld = accept && is_load && !misalign;
  assign issue_st = accept && is_store && !misalign;

  assign tag_in   = {i_Rd, i_Load_Store_Type, offset};
  assign tag_rd   = tag_out[TAG_W-1 -: RD_WIDTH];
  assign tag_type = tag_out[LS_SEL+1:2];
  assign tag_off  = tag_out[1:0];

  mem_stage_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (i_Clock),
    .rst_n     (i_Reset_N),
    .push      (issue_ld),
    .push_data (tag_in),
    .pop       (r_hs),
    .pop_data  (tag_out),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      rd_pending <= '0;
      wr_pending <= '0;
    end else begin
      case ({issue_ld, r_hs})
        2'b10:   rd_pending <= rd_pending + CNT_W'(1);
        2'b01:   rd_pending <= rd_pending - CNT_W'(1);
        default: ;
      endcase
      case ({issue_st, b_hs})
        2'b10:   wr_pending <= wr_pending + CNT_W'(1);
        2'b01:   wr_pending <= wr_pending - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // AW and W are raised together but each drops on its own ready.
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      s_axil_arvalid <= 1'b0;
      s_axil_araddr  <= '0;
      s_axil_awvalid <= 1'b0;
      s_axil_awaddr  <= '0;
      s_axil_wvalid  <= 1'b0;
      s_axil_wdata   <= '0;
      s_axil_wstrb   <= '0;
    end else begin
      if (issue_ld) begin
        s_axil_arvalid <= 1'b1;
        s_axil_araddr  <= word_addr;
      end else if (s_axil_arready) begin
        s_axil_arvalid <= 1'b0;
      end
      if (issue_st) begin
        s_axil_awvalid <= 1'b1;
        s_axil_awaddr  <= word_addr;
      end else if (s_axil_awready) begin
        s_axil_awvalid <= 1'b0;
      end
      if (issue_st) begin
        s_axil_wvalid <= 1'b1;
        s_axil_wdata  <= f_Store_Data(i_Load_Store_Type, i_Store_Data);
        s_axil_wstrb  <= f_Store_Strobe(i_Load_Store_Type, offset);
      end else if (s_axil_wready) begin
        s_axil_wvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      o_Wb_Valid     <= 1'b0;
      o_Wb_Rd        <= '0;
      o_Wb_Data      <= '0;
      o_Store_Commit <= 1'b0;
      o_Fault        <= 1'b0;
    end else begin
      o_Wb_Valid     <= r_hs && (s_axil_rresp == AXI_RESP_OKAY);
      o_Store_Commit <= b_hs && (s_axil_bresp == AXI_RESP_OKAY);
      o_Fault        <= (r_hs && (s_axil_rresp != AXI_RESP_OKAY))
                     || (b_hs && (s_axil_bresp != AXI_RESP_OKAY))
                     || (accept && misalign);
      if (r_hs) begin
        o_Wb_Rd   <= tag_rd;
        o_Wb_Data <= f_Lane_Extract(tag_type, tag_off, s_axil_rdata);
      end
    end
  end

  assign o_Idle = tag_empty && (wr_pending == '0)
               && !s_axil_arvalid && !s_axil_awvalid && !s_axil_wvalid;

endmodule

// File: tb/tb_mem_stage_axil.sv
// Directed bench for mem_stage_axil (default build): table of single load/store
// vectors plus hand sequences for outstanding loads, ordering barrier, errors and reset.
module tb_mem_stage_axil;
  import mem_stage_axil_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  ls_type;
  logic [31:0] addr, store_data;
  logic [4:0]  rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        store_commit, fault, idle;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage_axil dut (
    .i_Clock           (clk),
    .i_Reset_N         (rst_n),
    .i_Req_Valid       (req_valid),
    .o_Req_Ready       (req_ready),
    .i_Load_Store_Type (ls_type),
    .i_Addr            (addr),
    .i_Store_Data      (store_data),
    .i_Rd              (rd),
    .o_Wb_Valid        (wb_valid),
    .o_Wb_Rd           (wb_rd),
    .o_Wb_Data         (wb_data),
    .o_Store_Commit    (store_commit),
    .o_Fault           (fault),
    .o_Idle            (idle),
    .s_axil_araddr     (araddr),
    .s_axil_arvalid    (arvalid),
    .s_axil_arready    (arready),
    .s_axil_rdata      (rdata),
    .s_axil_rresp      (rresp),
    .s_axil_rvalid     (rvalid),
    .s_axil_rready     (rready),
    .s_axil_awaddr     (awaddr),
    .s_axil_awvalid    (awvalid),
    .s_axil_awready    (awready),
    .s_axil_wdata      (wdata),
    .s_axil_wstrb      (wstrb),
    .s_axil_wvalid     (wvalid),
    .s_axil_wready     (wready),
    .s_axil_bresp      (bresp),
    .s_axil_bvalid     (bvalid),
    .s_axil_bready     (bready)
  );

  typedef struct {
    logic [3:0]  t;
    logic [31:0] a;
    logic [31:0] din;   // rdata for loads, rs2 for stores
    logic [31:0] exp;   // writeback data for loads, wdata for stores
    logic [3:0]  strb;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic present(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    req_valid = 1'b1; ls_type = t; addr = a; store_data = d; rd = r;
  endtask

  task automatic run_load(input vec_t v);
    @(negedge clk); present(v.t, v.a, 32'h0, v.rd);
    #1 check("ld_ready", req_ready, 1);
    @(negedge clk); req_valid = 1'b0;
    check("ld_arvalid", arvalid, 1);
    check("ld_araddr", araddr, v.a & 32'hFFFF_FFFC);
    arready = 1'b1;
    @(negedge clk); arready = 1'b0;
    check("ld_ar_drop", arvalid, 0);
    check("ld_rready", rready, 1);
    rvalid = 1'b1; rdata = v.din; rresp = AXI_RESP_OKAY;
    @(negedge clk); rvalid = 1'b0;
    check("ld_wb_valid", wb_valid, 1);
    check("ld_wb_rd", wb_rd, v.rd);
    check("ld_wb_data", wb_data, v.exp);
    @(negedge clk);
    check("ld_wb_pulse", wb_valid, 0);
    check("ld_idle", idle, 1);
  endtask

  task automatic run_store(input vec_t v);
    @(negedge clk); present(v.t, v.a, v.din, 5'd0);
    #1 check("st_ready", req_ready, 1);
    @(negedge clk); req_valid = 1'b0;
    check("st_awvalid", awvalid, 1);
    check("st_wvalid", wvalid, 1);
    check("st_awaddr", awaddr, v.a & 32'hFFFF_FFFC);
    check("st_wdata", wdata, v.exp);
    check("st_wstrb", wstrb, v.strb);
    awready = 1'b1; wready = 1'b1;
    @(negedge clk); awready = 1'b0; wready = 1'b0;
    check("st_bready", bready, 1);
    check("st_no_early_commit", store_commit, 0);
    bvalid = 1'b1; bresp = AXI_RESP_OKAY;
    @(negedge clk); bvalid = 1'b0;
    check("st_commit", store_commit, 1);
    @(negedge clk);
    check("st_commit_pulse", store_commit, 0);
    check("st_idle", idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int commits;
    rst_n = 1'b0; req_valid = 1'b0; ls_type = LS_TYPE_NONE; addr = '0; store_data = '0; rd = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;

    vecs.push_back('{LS_TYPE_LW,  32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 4'h0, 5'd5});
    vecs.push_back('{LS_TYPE_LB,  32'h103, 32'h80FFFFFF, 32'hFFFFFF80, 4'h0, 5'd6});
    vecs.push_back('{LS_TYPE_LBU, 32'h103, 32'h80FFFFFF, 32'h00000080, 4'h0, 5'd7});
    vecs.push_back('{LS_TYPE_LHU, 32'h102, 32'h80FFFFFF, 32'h000080FF, 4'h0, 5'd8});
    vecs.push_back('{LS_TYPE_LH,  32'h102, 32'h80FFFFFF, 32'hFFFF80FF, 4'h0, 5'd9});
    vecs.push_back('{LS_TYPE_LH,  32'h100, 32'h12348765, 32'hFFFF8765, 4'h0, 5'd10});
    vecs.push_back('{LS_TYPE_LB,  32'h101, 32'h00007F00, 32'h0000007F, 4'h0, 5'd11});
    vecs.push_back('{LS_TYPE_SB,  32'h201, 32'h000000A5, 32'hA5A5A5A5, 4'b0010, 5'd0});
    vecs.push_back('{LS_TYPE_SB,  32'h203, 32'h1234567E, 32'h7E7E7E7E, 4'b1000, 5'd0});
    vecs.push_back('{LS_TYPE_SH,  32'h202, 32'h1234ABCD, 32'hABCDABCD, 4'b1100, 5'd0});
    vecs.push_back('{LS_TYPE_SW,  32'h204, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111, 5'd0});
`ifndef MEM_STAGE_MISALIGN_TRAP_EN
    vecs.push_back('{LS_TYPE_LW,  32'h101, 32'h01020304, 32'h01020304, 4'h0, 5'd12});
    vecs.push_back('{LS_TYPE_LH,  32'h103, 32'hBEEF0000, 32'hFFFFBEEF, 4'h0, 5'd13});
    vecs.push_back('{LS_TYPE_SH,  32'h201, 32'h5555AAAA, 32'hAAAAAAAA, 4'b0011, 5'd0});
`endif

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
    check("rst_pulses", {wb_valid, store_commit, fault}, 0);

    foreach (vecs[i]) begin
      if (f_Is_Load(vecs[i].t)) run_load(vecs[i]);
      else run_store(vecs[i]);
    end

    // NONE requests are accepted and dropped
    @(negedge clk); present(LS_TYPE_NONE, 32'h500, 32'h0, 5'd1);
    #1 check("none_ready", req_ready, 1);
    @(negedge clk); req_valid = 1'b0;
    check("none_no_axi", {arvalid, awvalid, wvalid}, 0);
    check("none_idle", idle, 1);

    // SH with AW delayed three cycles, W immediate: exactly one commit
    @(negedge clk); present(LS_TYPE_SH, 32'h202, 32'h1234ABCD, 5'd0);
    #1 check("shd_ready", req_ready, 1);
    @(negedge clk); req_valid = 1'b0;
    check("shd_wdata", wdata, 32'hABCDABCD);
    check("shd_wstrb", wstrb, 4'b1100);
    wready = 1'b1;
    commits = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); wready = 1'b0;
      check("shd_w_dropped", wvalid, 0);
      check("shd_aw_held", awvalid, 1);
      check("shd_aw_addr_stable", awaddr, 32'h200);
      check("shd_bready", bready, 1);
      if (store_commit) commits++;
    end
    awready = 1'b1;
    @(negedge clk); awready = 1'b0;
    check("shd_aw_dropped", awvalid, 0);
    bvalid = 1'b1; bresp = AXI_RESP_OKAY;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); bvalid = 1'b0;
      if (store_commit) commits++;
    end
    check("shd_commit_count", commits, 1);
    check("shd_idle", idle, 1);

    // Three loads with R held off: third blocked until first R retires
    @(negedge clk); present(LS_TYPE_LW, 32'h10, 32'h0, 5'd1);
    #1 check("ml_ready_a", req_ready, 1);
    @(negedge clk); req_valid = 1'b0; arready = 1'b1;
    @(negedge clk); arready = 1'b0; present(LS_TYPE_LW, 32'h14, 32'h0, 5'd2);
    #1 check("ml_ready_b", req_ready, 1);
    @(negedge clk); req_valid = 1'b0; arready = 1'b1;
    @(negedge clk); arready = 1'b0; present(LS_TYPE_LW, 32'h18, 32'h0, 5'd3);
    #1 check("ml_full_blocks", req_ready, 0);
    @(negedge clk);
    check("ml_still_blocked", req_ready, 0);
    rvalid = 1'b1; rdata = 32'h11111111; rresp = AXI_RESP_OKAY;
    #1 check("ml_ready_on_r", req_ready, 1);
    @(negedge clk); req_valid = 1'b0; rvalid = 1'b0;
    check("ml_wb1_valid", wb_valid, 1);
    check("ml_wb1_rd", wb_rd, 1);
    check("ml_wb1_data", wb_data, 32'h11111111);
    check("ml_ar_c", arvalid, 1);
    check("ml_ar_c_addr", araddr, 32'h18);
    arready = 1'b1;
    @(negedge clk); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h22222222;
    @(negedge clk);
    check("ml_wb2_rd", wb_rd, 2);
    check("ml_wb2_data", wb_data, 32'h22222222);
    rdata = 32'h33333333;
    @(negedge clk); rvalid = 1'b0;
    check("ml_wb3_valid", wb_valid, 1);
    check("ml_wb3_rd", wb_rd, 3);
    check("ml_wb3_data", wb_data, 32'h33333333);
    @(negedge clk);
    check("ml_idle", idle, 1);
    check("ml_rready_low", rready, 0);

    // Store pending blocks a load until B; then SLVERR load faults without writeback
    @(negedge clk); present(LS_TYPE_SW, 32'h300, 32'h0BADF00D, 5'd0);
    #1 check("bar_st_ready", req_ready, 1);
    @(negedge clk); req_valid = 1'b0; awready = 1'b1; wready = 1'b1;
    @(negedge clk); awready = 1'b0; wready = 1'b0;
    present(LS_TYPE_LW, 32'h304, 32'h0, 5'd7);
    #1 check("bar_ld_blocked", req_ready, 0);
    @(negedge clk);
    check("bar_ld_blocked2", req_ready, 0);
    bvalid = 1'b1; bresp = AXI_RESP_OKAY;
    #1 check("bar_blocked_during_b", req_ready, 0);
    @(negedge clk); bvalid = 1'b0;
    check("bar_commit", store_commit, 1);
    #1 check("bar_ld_ready", req_ready, 1);
    @(negedge clk); req_valid = 1'b0;
    check("bar_arvalid", arvalid, 1);
    arready = 1'b1;
    @(negedge clk); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h12345678; rresp = AXI_RESP_SLVERR;
    @(negedge clk); rvalid = 1'b0; rresp = AXI_RESP_OKAY;
    check("err_fault", fault, 1);
    check("err_no_wb", wb_valid, 0);
    @(negedge clk);
    check("err_fault_pulse", fault, 0);
    check("err_idle", idle, 1);

    // Async reset with two reads in flight
    @(negedge clk); present(LS_TYPE_LW, 32'h400, 32'h0, 5'd8);
    @(negedge clk); req_valid = 1'b0; arready = 1'b1;
    @(negedge clk); arready = 1'b0; present(LS_TYPE_LW, 32'h404, 32'h0, 5'd9);
    #1 check("rs_ready_second", req_ready, 1);
    @(negedge clk); req_valid = 1'b0; ls_type = LS_TYPE_NONE;
    check("rs_arvalid_before", arvalid, 1);
    check("rs_busy_before", idle, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rs_arvalid", arvalid, 0);
    check("rs_rready", rready, 0);
    check("rs_idle", idle, 1);
    check("rs_ready", req_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rs_idle_after", idle, 1);
    check("rs_no_wb", wb_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
